// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_7seg
// Purpose  : Registered BCD / hex to seven-segment decoder for one display
//            digit. The pattern for the code sampled on a rising clock edge
//            appears on the outputs straight from flops after that edge.
//            Codes 10-15 either blank the digit and raise 'invalid'
//            (HEX_EN=0) or are shown as the glyphs A b C d E F (HEX_EN=1).
// Params   : ACTIVE_LOW - 1: lit segment driven 0 (common anode)
//                         0: lit segment driven 1 (common cathode)
//            HEX_EN     - 0: blank codes 10-15; 1: show hex glyphs
// Ports    : clk     - system clock, rising edge
//            rst     - asynchronous active-high reset, outputs blank
//            bcd     - 4-bit code to display
//            seg     - segment drive, {a,b,c,d,e,f,g} = seg[6:0]
//            invalid - code was 10-15 while HEX_EN=0
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_7seg #(
    parameter int ACTIVE_LOW = 1,
    parameter int HEX_EN     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd,
    output logic [6:0] seg,
    output logic       invalid
);

    // Lit patterns, 1 = segment on, bit order abcdefg.
    localparam logic [6:0] C_LIT_0     = 7'b1111110;
    localparam logic [6:0] C_LIT_1     = 7'b0110000;
    localparam logic [6:0] C_LIT_2     = 7'b1101101;
    localparam logic [6:0] C_LIT_3     = 7'b1111001;
    localparam logic [6:0] C_LIT_4     = 7'b0110011;
    localparam logic [6:0] C_LIT_5     = 7'b1011011;
    localparam logic [6:0] C_LIT_6     = 7'b1011111;
    localparam logic [6:0] C_LIT_7     = 7'b1110000;
    localparam logic [6:0] C_LIT_8     = 7'b1111111;
    localparam logic [6:0] C_LIT_9     = 7'b1111011;
    localparam logic [6:0] C_LIT_A     = 7'b1110111;
    localparam logic [6:0] C_LIT_B     = 7'b0011111;
    localparam logic [6:0] C_LIT_C     = 7'b1001110;
    localparam logic [6:0] C_LIT_D     = 7'b0111101;
    localparam logic [6:0] C_LIT_E     = 7'b1001111;
    localparam logic [6:0] C_LIT_F     = 7'b1000111;
    localparam logic [6:0] C_LIT_BLANK = 7'b0000000;

    // Blank as seen on the pins: all segments off in the chosen polarity.
    localparam logic [6:0] C_SEG_BLANK = (ACTIVE_LOW != 0) ? ~C_LIT_BLANK : C_LIT_BLANK;

    logic [6:0] w_lit_all;   // glyph for every code, hex included
    logic       w_is_hex;    // code is 10-15
    logic [6:0] w_lit;       // glyph after the BCD-mode blanking rule
    logic       w_invalid;
    logic [6:0] w_seg;       // glyph in pin polarity
    logic [6:0] r_seg;
    logic       r_invalid;

    // All 16 codes are listed, so every X-free input has a defined glyph.
    always_comb begin
        w_lit_all = C_LIT_BLANK;
        case (bcd)
            4'h0: w_lit_all = C_LIT_0;
            4'h1: w_lit_all = C_LIT_1;
            4'h2: w_lit_all = C_LIT_2;
            4'h3: w_lit_all = C_LIT_3;
            4'h4: w_lit_all = C_LIT_4;
            4'h5: w_lit_all = C_LIT_5;
            4'h6: w_lit_all = C_LIT_6;
            4'h7: w_lit_all = C_LIT_7;
            4'h8: w_lit_all = C_LIT_8;
            4'h9: w_lit_all = C_LIT_9;
            4'hA: w_lit_all = C_LIT_A;
            4'hB: w_lit_all = C_LIT_B;
            4'hC: w_lit_all = C_LIT_C;
            4'hD: w_lit_all = C_LIT_D;
            4'hE: w_lit_all = C_LIT_E;
            4'hF: w_lit_all = C_LIT_F;
        endcase
    end

    assign w_is_hex = (bcd >= 4'd10);

    // In BCD mode the hex glyphs are suppressed and flagged instead.
    generate
        if (HEX_EN != 0) begin : g_hex_on
            assign w_lit     = w_lit_all;
            assign w_invalid = 1'b0;
        end else begin : g_hex_off
            assign w_lit     = w_is_hex ? C_LIT_BLANK : w_lit_all;
            assign w_invalid = w_is_hex;
        end
    endgenerate

    generate
        if (ACTIVE_LOW != 0) begin : g_active_low
            assign w_seg = ~w_lit;
        end else begin : g_active_high
            assign w_seg = w_lit;
        end
    endgenerate

    // Outputs come straight from these flops so the pins never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg     <= C_SEG_BLANK;
            r_invalid <= 1'b0;
        end else begin
            r_seg     <= w_seg;
            r_invalid <= w_invalid;
        end
    end

    assign seg     = r_seg;
    assign invalid = r_invalid;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_7seg
// Purpose  : Self-checking bench for bcd_to_7seg. Three instances share one
//            stimulus: BCD mode active-low, hex mode active-low, and BCD mode
//            active-high. Expected outputs come from a glyph table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_7seg;

    logic       clk;
    logic       rst;
    logic [3:0] bcd;

    logic [6:0] seg_bcd, seg_hex, seg_pos;
    logic       inv_bcd, inv_hex, inv_pos;

    int checks   = 0;
    int failures = 0;

    // Model state: code that the flops should currently hold, or blank.
    int cur_code = 0;
    bit blanked  = 1'b1;

    bcd_to_7seg #(.ACTIVE_LOW(1), .HEX_EN(0)) u_dut_bcd (
        .clk(clk), .rst(rst), .bcd(bcd), .seg(seg_bcd), .invalid(inv_bcd)
    );
    bcd_to_7seg #(.ACTIVE_LOW(1), .HEX_EN(1)) u_dut_hex (
        .clk(clk), .rst(rst), .bcd(bcd), .seg(seg_hex), .invalid(inv_hex)
    );
    bcd_to_7seg #(.ACTIVE_LOW(0), .HEX_EN(0)) u_dut_pos (
        .clk(clk), .rst(rst), .bcd(bcd), .seg(seg_pos), .invalid(inv_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyph table, 1 = lit, abcdefg, indexed by code.
    logic [6:0] lit_tab [16];
    initial begin
        lit_tab[0]  = 7'b1111110; lit_tab[1]  = 7'b0110000;
        lit_tab[2]  = 7'b1101101; lit_tab[3]  = 7'b1111001;
        lit_tab[4]  = 7'b0110011; lit_tab[5]  = 7'b1011011;
        lit_tab[6]  = 7'b1011111; lit_tab[7]  = 7'b1110000;
        lit_tab[8]  = 7'b1111111; lit_tab[9]  = 7'b1111011;
        lit_tab[10] = 7'b1110111; lit_tab[11] = 7'b0011111;
        lit_tab[12] = 7'b1001110; lit_tab[13] = 7'b0111101;
        lit_tab[14] = 7'b1001111; lit_tab[15] = 7'b1000111;
    end

    // Returns {invalid, seg} for a configuration.
    function automatic logic [7:0] model(int code, bit blank, bit al, bit hex);
        logic [6:0] lit;
        logic       inv;
        lit = 7'b0000000;
        inv = 1'b0;
        if (!blank) begin
            if (code >= 10 && !hex) begin
                inv = 1'b1;
            end else begin
                lit = lit_tab[code];
            end
        end
        return {inv, (al ? ~lit : lit)};
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed inv/seg=%b/%b expected %b/%b",
                   tag, obs[7], obs[6:0], exp[7], exp[6:0]);
        end
    endtask

    task automatic check_all(string tag);
        chk($sformatf("%s_bcdmode code=%0d", tag, cur_code), {inv_bcd, seg_bcd},
            model(cur_code, blanked, 1'b1, 1'b0));
        chk($sformatf("%s_hexmode code=%0d", tag, cur_code), {inv_hex, seg_hex},
            model(cur_code, blanked, 1'b1, 1'b1));
        chk($sformatf("%s_activehigh code=%0d", tag, cur_code), {inv_pos, seg_pos},
            model(cur_code, blanked, 1'b0, 1'b0));
    endtask

    // Drive a code, confirm outputs hold before the edge, then check after it.
    task automatic apply(int code, string tag);
        @(negedge clk);
        bcd = 4'(code);
        #1;
        check_all({tag, "_pre_edge"});
        @(posedge clk);
        cur_code = code;
        blanked  = 1'b0;
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        bcd = 4'd0;

        // Asynchronous reset with no clock edge yet.
        #2;
        check_all("reset_initial");
        @(negedge clk);
        bcd = 4'd7;
        rst = 1'b0;
        @(posedge clk);
        cur_code = 7;
        blanked  = 1'b0;
        #1;
        check_all("reset_release");

        // Full sweep 0..15 one per cycle.
        for (int c = 0; c < 16; c++) apply(c, "sweep");

        // Spot checks of hex glyphs against literal pin values.
        apply(10, "hexlit");
        chk("hex_A_literal", {inv_hex, seg_hex}, {1'b0, 7'b0001000});
        apply(13, "hexlit");
        chk("hex_d_literal", {inv_hex, seg_hex}, {1'b0, 7'b1000010});
        chk("bcd_13_blank_literal", {inv_bcd, seg_bcd}, {1'b1, 7'b1111111});

        // Back-to-back 9, 10, 0.
        apply(9, "b2b");
        apply(10, "b2b");
        apply(0, "b2b");

        // Hold 5 for four cycles.
        for (int i = 0; i < 4; i++) apply(5, "hold");
        chk("hold5_literal", {inv_bcd, seg_bcd}, {1'b0, 7'b0100100});

        // Mid-cycle reset while displaying 8.
        apply(8, "pre_reset");
        #3;
        rst = 1'b1;
        #1;
        blanked = 1'b1;
        check_all("reset_async_mid");
        @(negedge clk);
        bcd = 4'd3;
        @(posedge clk);
        #1;
        check_all("reset_held");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        cur_code = 3;
        blanked  = 1'b0;
        #1;
        check_all("reset_release_3");
        chk("release3_literal", {inv_bcd, seg_bcd}, {1'b0, 7'b0000110});

        // Randomized codes.
        for (int i = 0; i < 200; i++) apply(int'($urandom_range(0, 15)), "random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
